// File: rtl/trace_capture_pkg.sv
// rtl/trace_capture_pkg.sv - shared types and constants for the trace recorder
package trace_capture_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int FLAG_WB = 2;
    localparam int FLAG_RD = 1;
    localparam int FLAG_WR = 0;

    localparam int CYCLE_W = 16;
    localparam int ENTRY_W = CYCLE_W + 3 + 32 + 32;

    typedef struct packed {
        logic [CYCLE_W-1:0] cycle;
        logic [2:0]         flags;
        logic [31:0]        wbdata;
        logic [31:0]        memdata;
    } entry_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - single-clock FIFO with extra-MSB pointers; head reads as zero when empty
module trace_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wptr;
    logic [AW:0]      rptr;
    logic             do_push;
    logic             do_pop;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign head  = empty ? '0 : mem[rptr[AW-1:0]];

    // A pop on a full FIFO frees the slot the same edge, so the push may land.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wptr[AW-1:0]] <= wr_data;
                wptr              <= wptr + PTR_ONE;
            end
            if (do_pop) begin
                rptr <= rptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/trace_capture.sv
// rtl/trace_capture.sv - captures WB/MEM events into a FIFO and detects end-of-program drain
module trace_capture
    import trace_capture_pkg::*;
#(
    parameter int NMEM  = 16,
    parameter int DEPTH = 16,
    parameter int DRAIN = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] if_pc,
    input  logic [31:0] wb_regdata,
    input  logic        wb_regwrite,
    input  logic [31:0] mem_memdata,
    input  logic        mem_memread,
    input  logic        mem_memwrite,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_cycle,
    output logic [2:0]  out_flags,
    output logic [31:0] out_wbdata,
    output logic [31:0] out_memdata,
    output logic        overflow,
    output logic        done,
    output logic [15:0] cycle_count,
    output logic [15:0] retired
);

    localparam logic [31:0] PC_END = 32'(4 * NMEM);
    localparam int DW = (DRAIN > 1) ? $clog2(DRAIN) : 1;

    state_t          state;
    logic            pc_end;
    logic [DW-1:0]   drain_cnt;
    logic            event_seen;
    logic            capture;
    logic            pop;
    logic            push;
    logic            drop;
    logic            full;
    logic            empty;
    entry_t          entry;
    entry_t          head;

    always_comb begin
        entry                = '0;
        entry.cycle          = cycle_count;
        entry.flags[FLAG_WB] = wb_regwrite;
        entry.flags[FLAG_RD] = mem_memread;
        entry.flags[FLAG_WR] = mem_memwrite;
        entry.wbdata         = wb_regdata;
        entry.memdata        = mem_memdata;
    end

    assign event_seen = wb_regwrite | mem_memread | mem_memwrite;
    assign capture    = event_seen && (state != ST_DONE);
    assign pop        = out_valid & out_ready;
    assign push       = capture && (!full || pop);
    assign drop       = capture && full && !pop;

    trace_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (entry),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty)
    );

    assign out_valid   = ~empty;
    assign out_cycle   = head.cycle;
    assign out_flags   = head.flags;
    assign out_wbdata  = head.wbdata;
    assign out_memdata = head.memdata;

    // The PC compare is registered, so DRAIN is entered one edge after the
    // end-of-program PC is sampled; done lands DRAIN+1 edges after that sample.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_RUN;
            pc_end      <= 1'b0;
            drain_cnt   <= '0;
            done        <= 1'b0;
            overflow    <= 1'b0;
            cycle_count <= '0;
            retired     <= '0;
        end else begin
            pc_end <= (if_pc >= PC_END);
            if (state != ST_DONE) begin
                cycle_count <= sat_inc(cycle_count);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            if (push && wb_regwrite) begin
                retired <= sat_inc(retired);
            end
            case (state)
                ST_RUN: begin
                    if (pc_end) begin
                        state     <= ST_DRAIN;
                        drain_cnt <= DW'(DRAIN - 1);
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state <= ST_DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_trace_capture.sv
// tb/tb_trace_capture.sv - directed bench for trace_capture with NMEM=4, DEPTH=4, DRAIN=5
module tb_trace_capture;
    import trace_capture_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] if_pc;
    logic [31:0] wb_regdata;
    logic        wb_regwrite;
    logic [31:0] mem_memdata;
    logic        mem_memread;
    logic        mem_memwrite;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_cycle;
    logic [2:0]  out_flags;
    logic [31:0] out_wbdata;
    logic [31:0] out_memdata;
    logic        overflow;
    logic        done;
    logic [15:0] cycle_count;
    logic [15:0] retired;

    int total = 0;
    int bad   = 0;

    trace_capture #(
        .NMEM  (4),
        .DEPTH (4),
        .DRAIN (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .if_pc        (if_pc),
        .wb_regdata   (wb_regdata),
        .wb_regwrite  (wb_regwrite),
        .mem_memdata  (mem_memdata),
        .mem_memread  (mem_memread),
        .mem_memwrite (mem_memwrite),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_cycle    (out_cycle),
        .out_flags    (out_flags),
        .out_wbdata   (out_wbdata),
        .out_memdata  (out_memdata),
        .overflow     (overflow),
        .done         (done),
        .cycle_count  (cycle_count),
        .retired      (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in;
        wb_regwrite  = 1'b0;
        mem_memread  = 1'b0;
        mem_memwrite = 1'b0;
        wb_regdata   = 32'h0;
        mem_memdata  = 32'h0;
    endtask

    task automatic do_reset;
        reset     = 1'b1;
        if_pc     = 32'h0;
        out_ready = 1'b0;
        clear_in();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        do_reset();
        check("rst_valid", out_valid, 0);
        check("rst_cycle", out_cycle, 0);
        check("rst_flags", out_flags, 0);
        check("rst_wbdata", out_wbdata, 0);
        check("rst_memdata", out_memdata, 0);
        check("rst_overflow", overflow, 0);
        check("rst_done", done, 0);
        check("rst_cycle_count", cycle_count, 0);
        check("rst_retired", retired, 0);
        check("rst_state", dut.state, ST_RUN);

        // single writeback event presented while cycle_count is 3
        repeat (3) tick();
        check("a_cycle_count", cycle_count, 3);
        wb_regwrite = 1'b1;
        wb_regdata  = 32'h2A;
        out_ready   = 1'b1;
        check("a_no_bypass", out_valid, 0);
        tick();
        clear_in();
        check("a_valid", out_valid, 1);
        check("a_cycle", out_cycle, 3);
        check("a_flags", out_flags, 3'b100);
        check("a_wbdata", out_wbdata, 32'h2A);
        check("a_retired", retired, 1);
        tick();
        check("a_popped", out_valid, 0);

        // combined wb + mem write in one entry
        wb_regwrite  = 1'b1;
        wb_regdata   = 32'h55;
        mem_memwrite = 1'b1;
        mem_memdata  = 32'hDEADBEEF;
        tick();
        clear_in();
        check("b_flags", out_flags, 3'b101);
        check("b_memdata", out_memdata, 32'hDEADBEEF);
        check("b_wbdata", out_wbdata, 32'h55);
        check("b_cycle", out_cycle, 5);
        check("b_retired", retired, 2);
        tick();
        check("b_popped", out_valid, 0);

        // memory read alone does not count as retired
        mem_memread = 1'b1;
        mem_memdata = 32'h1234;
        tick();
        clear_in();
        check("r_flags", out_flags, 3'b010);
        check("r_memdata", out_memdata, 32'h1234);
        check("r_retired", retired, 2);
        tick();

        // fill, full+pop+push, then overflow drop, then drain in order
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wb_regwrite = 1'b1;
            wb_regdata  = 32'h100 + 32'(i);
            tick();
        end
        check("c_full_overflow", overflow, 0);
        check("c_full_retired", retired, 4);
        check("c_full_head", out_wbdata, 32'h100);
        wb_regdata = 32'h104;
        out_ready  = 1'b1;
        tick();
        check("c_swap_overflow", overflow, 0);
        check("c_swap_retired", retired, 5);
        check("c_swap_head", out_wbdata, 32'h101);
        out_ready  = 1'b0;
        wb_regdata = 32'h105;
        tick();
        clear_in();
        check("c_drop_overflow", overflow, 1);
        check("c_drop_retired", retired, 5);
        check("c_hold_head", out_wbdata, 32'h101);
        check("c_hold_cycle", out_cycle, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("c_pop_valid", out_valid, 1);
            check("c_pop_data", out_wbdata, 32'h101 + 32'(i));
            check("c_pop_cycle", out_cycle, 16'(1 + i));
            tick();
        end
        check("c_empty_valid", out_valid, 0);
        check("c_empty_data", out_wbdata, 0);

        // end of program: PC 0x10 first sampled at edge 10, done after edge 16
        do_reset();
        if_pc = 32'hF;
        repeat (9) tick();
        check("e_below_end", dut.state, ST_RUN);
        if_pc = 32'h10;
        repeat (6) tick();
        check("e_not_done_15", done, 0);
        wb_regwrite = 1'b1;
        wb_regdata  = 32'h77;
        tick();
        check("e_done_16", done, 1);
        check("e_cycle_count_16", cycle_count, 16);
        check("e_last_captured", out_valid, 1);
        check("e_last_cycle", out_cycle, 15);
        check("e_last_data", out_wbdata, 32'h77);
        wb_regdata = 32'h88;
        out_ready  = 1'b1;
        tick();
        clear_in();
        check("e_ignored", out_valid, 0);
        check("e_retired", retired, 1);
        out_ready = 1'b0;
        tick();
        check("e_frozen", cycle_count, 16);
        check("e_done_sticky", done, 1);

        // reset while in DRAIN with 3 entries queued
        do_reset();
        if_pc = 32'h10;
        for (int i = 0; i < 3; i++) begin
            wb_regwrite = 1'b1;
            wb_regdata  = 32'h300 + 32'(i);
            tick();
        end
        clear_in();
        check("f_pre_state", dut.state, ST_DRAIN);
        check("f_pre_valid", out_valid, 1);
        check("f_pre_retired", retired, 3);
        reset = 1'b1;
        if_pc = 32'h0;
        tick();
        reset = 1'b0;
        check("f_valid", out_valid, 0);
        check("f_done", done, 0);
        check("f_cycle_count", cycle_count, 0);
        check("f_retired", retired, 0);
        check("f_wbdata", out_wbdata, 0);
        check("f_state", dut.state, ST_RUN);
        tick();
        check("f_restart_count", cycle_count, 1);
        check("f_restart_state", dut.state, ST_RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
